// File: rtl/tx_packet_ctrl.sv
// Transmit packet framer: SYNC, PID, FIFO payload, optional CRC16, EOP; also ACK/NAK handshakes.
// Optional CRC16 trailer enabled by defining TCU_CRC16_EN.
module tx_packet_ctrl #(
  parameter int         LEN_W      = 10,
  parameter logic [7:0] SYNC_BYTE  = 8'h80,
  parameter logic [7:0] PID_DATA   = 8'hC3,
  parameter logic [7:0] PID_ACK    = 8'hD2,
  parameter logic [7:0] PID_NAK    = 8'h5A,
  parameter int         UR_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_transmit,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             tx_send_good,
  input  logic             tx_send_bad,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eop,
  output logic             sending,
  output logic             tx_done,
  output logic             tx_abort
);

  localparam int EC_W = $clog2(UR_TIMEOUT + 1);

`ifdef TCU_CRC16_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_PID    = 3'd2,
`ifdef TCU_CRC16_EN
    ST_CRC_LO = 3'd4,
    ST_CRC_HI = 3'd5,
`endif
    ST_DATA   = 3'd3
  } state_t;

  state_t           state_r, state_s;
  logic [7:0]       pid_r, pid_s;
  logic             hs_r, hs_s;
  logic [LEN_W-1:0] rem_r, rem_s;
  logic [EC_W-1:0]  ec_r, ec_s;
  logic             done_s, abort_s;
  logic [7:0]       byte_r, byte_s;
  logic             ctl_valid_r, ctl_valid_s;
  logic             eop_r, eop_s;
  logic             sending_r, done_r, abort_r;
  logic             accept_s;

`ifdef TCU_CRC16_EN
  logic [15:0] crc_r, crc_s;

  // Reflected USB CRC16 (poly 0x8005 as 0xA001), one byte LSB-first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction
`endif

  // Payload bytes bypass the output registers so the FIFO head streams at full rate
  assign out_valid = (state_r == ST_DATA) ? !fifo_empty : ctl_valid_r;
  assign out_data  = (state_r == ST_DATA) ? fifo_data : byte_r;
  assign out_eop   = eop_r;
  assign fifo_rd   = (state_r == ST_DATA) && !fifo_empty && out_ready;
  assign sending   = sending_r;
  assign tx_done   = done_r;
  assign tx_abort  = abort_r;
  assign accept_s  = out_valid && out_ready;

  // Next-state, counters and request latching
  always_comb begin
    state_s = state_r;
    pid_s   = pid_r;
    hs_s    = hs_r;
    rem_s   = rem_r;
    ec_s    = ec_r;
    done_s  = 1'b0;
    abort_s = 1'b0;
`ifdef TCU_CRC16_EN
    crc_s   = crc_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (tx_transmit) begin
          state_s = ST_SYNC;
          pid_s   = PID_DATA;
          hs_s    = 1'b0;
          rem_s   = tx_len;
`ifdef TCU_CRC16_EN
          crc_s   = 16'hFFFF;
`endif
        end else if (tx_send_bad) begin
          state_s = ST_SYNC;
          pid_s   = PID_NAK;
          hs_s    = 1'b1;
          rem_s   = {LEN_W{1'b0}};
        end else if (tx_send_good) begin
          state_s = ST_SYNC;
          pid_s   = PID_ACK;
          hs_s    = 1'b1;
          rem_s   = {LEN_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (accept_s) state_s = ST_PID;
        else          state_s = ST_SYNC;
      end
      ST_PID: begin
        if (!accept_s) begin
          state_s = ST_PID;
        end else if (!hs_r && (rem_r != {LEN_W{1'b0}})) begin
          state_s = ST_DATA;
          ec_s    = {EC_W{1'b0}};
`ifdef TCU_CRC16_EN
        end else if (!hs_r) begin
          state_s = ST_CRC_LO;
`endif
        end else begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end
      end
      ST_DATA: begin
        if (fifo_empty) begin
          // Starved too long: drop the packet without EOP so the receiver discards it
          if (ec_r == EC_W'(UR_TIMEOUT - 1)) begin
            state_s = ST_IDLE;
            abort_s = 1'b1;
            ec_s    = {EC_W{1'b0}};
          end else begin
            ec_s    = ec_r + {{(EC_W-1){1'b0}}, 1'b1};
          end
        end else if (out_ready) begin
          ec_s  = {EC_W{1'b0}};
          rem_s = rem_r - {{(LEN_W-1){1'b0}}, 1'b1};
`ifdef TCU_CRC16_EN
          crc_s = crc16_byte(crc_r, fifo_data);
          if (rem_r == {{(LEN_W-1){1'b0}}, 1'b1}) state_s = ST_CRC_LO;
          else                                    state_s = ST_DATA;
`else
          if (rem_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_DATA;
          end
`endif
        end else begin
          ec_s = {EC_W{1'b0}};
        end
      end
`ifdef TCU_CRC16_EN
      ST_CRC_LO: begin
        if (accept_s) state_s = ST_CRC_HI;
        else          state_s = ST_CRC_LO;
      end
      ST_CRC_HI: begin
        if (accept_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_CRC_HI;
        end
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so they register alongside it
  always_comb begin
    byte_s      = 8'h00;
    ctl_valid_s = 1'b0;
    eop_s       = 1'b0;
    case (state_s)
      ST_SYNC: begin
        byte_s      = SYNC_BYTE;
        ctl_valid_s = 1'b1;
      end
      ST_PID: begin
        byte_s      = pid_s;
        ctl_valid_s = 1'b1;
        eop_s       = hs_s || ((rem_s == {LEN_W{1'b0}}) && !CRC_EN);
      end
      ST_DATA: begin
        eop_s = (rem_s == {{(LEN_W-1){1'b0}}, 1'b1}) && !CRC_EN;
      end
`ifdef TCU_CRC16_EN
      ST_CRC_LO: begin
        byte_s      = ~crc_s[7:0];
        ctl_valid_s = 1'b1;
      end
      ST_CRC_HI: begin
        byte_s      = ~crc_s[15:8];
        ctl_valid_s = 1'b1;
        eop_s       = 1'b1;
      end
`endif
      default: begin
        byte_s      = 8'h00;
        ctl_valid_s = 1'b0;
        eop_s       = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pid_r       <= 8'h00;
      hs_r        <= 1'b0;
      rem_r       <= {LEN_W{1'b0}};
      ec_r        <= {EC_W{1'b0}};
      byte_r      <= 8'h00;
      ctl_valid_r <= 1'b0;
      eop_r       <= 1'b0;
      sending_r   <= 1'b0;
      done_r      <= 1'b0;
      abort_r     <= 1'b0;
`ifdef TCU_CRC16_EN
      crc_r       <= 16'hFFFF;
`endif
    end else begin
      state_r     <= state_s;
      pid_r       <= pid_s;
      hs_r        <= hs_s;
      rem_r       <= rem_s;
      ec_r        <= ec_s;
      byte_r      <= byte_s;
      ctl_valid_r <= ctl_valid_s;
      eop_r       <= eop_s;
      sending_r   <= (state_s != ST_IDLE);
      done_r      <= done_s;
      abort_r     <= abort_s;
`ifdef TCU_CRC16_EN
      crc_r       <= crc_s;
`endif
    end
  end

endmodule

// File: tb/tb_tx_packet_ctrl.sv
// Directed scoreboard bench for tx_packet_ctrl; expected CRC bytes only when TCU_CRC16_EN is defined.
module tb_tx_packet_ctrl;

`ifdef TCU_CRC16_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tx_transmit, tx_send_good, tx_send_bad;
  logic [9:0] tx_len;
  logic       fifo_empty, fifo_rd, out_valid, out_ready, out_eop;
  logic       sending, tx_done, tx_abort;
  logic [7:0] fifo_data, out_data;

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  int done_cnt = 0, abort_cnt = 0, rd_cnt = 0, eop_cnt = 0;
  logic [15:0] exp_q[$];

  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_eop   = 1'b0;

  tx_packet_ctrl dut (
    .clk(clk), .rst(rst), .tx_transmit(tx_transmit), .tx_len(tx_len),
    .tx_send_good(tx_send_good), .tx_send_bad(tx_send_bad),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_eop(out_eop), .sending(sending), .tx_done(tx_done), .tx_abort(tx_abort)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fifo(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  task automatic push_exp(input logic [7:0] b, input logic eop);
    exp_q.push_back({7'd0, eop, b});
  endtask

  task automatic wait_done(input int start, input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt == start; i++) tick();
    chk(tag, done_cnt - start, 1);
  endtask

`ifdef TCU_CRC16_EN
  // Non-reflected shift-register form, bits fed LSB-first
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    return c;
  endfunction

  task automatic push_crc(input logic [15:0] c);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    push_exp(~r[7:0], 1'b0);
    push_exp(~r[15:8], 1'b1);
  endtask
`endif

  // Monitor: scoreboard pops on accept, pulse counters, hold-stability checks
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_done)  done_cnt++;
      if (tx_abort) abort_cnt++;
      if (fifo_rd) begin
        rd_cnt++;
        chk("rd_only_on_accept", {31'd0, out_valid && out_ready}, 32'd1);
      end
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
        chk("stall_eop", {31'd0, out_eop}, {31'd0, prev_eop});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {23'd0, out_eop, out_data}, 32'hFFFF_FFFF);
        end else begin
          chk("byte", {23'd0, out_eop, out_data}, {16'd0, exp_q.pop_front()});
        end
        if (out_eop) eop_cnt++;
      end
    end
    prev_stall <= out_valid && !out_ready && !rst;
    prev_data  <= out_data;
    prev_eop   <= out_eop;
  end

  initial begin
    int s_done, s_rd, s_eop, s_abort;
    rst = 1'b1; tx_transmit = 1'b0; tx_send_good = 1'b0; tx_send_bad = 1'b0;
    tx_len = 10'd0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_eop", {31'd0, out_eop}, 32'd0);
    chk("rst_sending", {31'd0, sending}, 32'd0);
    chk("rst_done_abort_rd", {29'd0, tx_done, tx_abort, fifo_rd}, 32'd0);
    rst = 1'b0;
    tick();

    // ACK handshake
    s_eop = eop_cnt;
    push_exp(8'h80, 1'b0); push_exp(8'hD2, 1'b1);
    tx_send_good = 1'b1; tick(); tx_send_good = 1'b0;
    chk("ack_sending_1", {31'd0, sending}, 32'd1);
    chk("ack_sync", {23'd0, out_valid, out_data}, 32'h180);
    tick();
    chk("ack_sending_2", {31'd0, sending}, 32'd1);
    tick();
    chk("ack_done", {30'd0, tx_done, sending}, 32'd2);
    tick();
    chk("ack_done_pulse", {31'd0, tx_done}, 32'd0);
    chk("ack_sb_empty", exp_q.size(), 32'd0);
    chk("ack_eop_cnt", eop_cnt - s_eop, 32'd1);

    // Simultaneous requests: data wins
    s_done = done_cnt; s_rd = rd_cnt;
    push_fifo(8'hAA); push_fifo(8'h55);
    push_exp(8'h80, 1'b0); push_exp(8'hC3, 1'b0); push_exp(8'hAA, 1'b0); push_exp(8'h55, !CRC_ON);
`ifdef TCU_CRC16_EN
    push_crc(crc_step(crc_step(16'hFFFF, 8'hAA), 8'h55));
`endif
    tx_transmit = 1'b1; tx_send_bad = 1'b1; tx_send_good = 1'b1; tx_len = 10'd2;
    tick();
    tx_transmit = 1'b0; tx_send_bad = 1'b0; tx_send_good = 1'b0;
    wait_done(s_done, 30, "prio_done_timeout");
    chk("prio_sb_empty", exp_q.size(), 32'd0);
    chk("prio_rd_cnt", rd_cnt - s_rd, 32'd2);

    // Backpressure: out_ready toggles every cycle
    s_done = done_cnt; s_rd = rd_cnt;
    push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33);
    push_exp(8'h80, 1'b0); push_exp(8'hC3, 1'b0); push_exp(8'h11, 1'b0);
    push_exp(8'h22, 1'b0); push_exp(8'h33, !CRC_ON);
`ifdef TCU_CRC16_EN
    push_crc(crc_step(crc_step(crc_step(16'hFFFF, 8'h11), 8'h22), 8'h33));
`endif
    tx_transmit = 1'b1; tx_len = 10'd3;
    tick();
    tx_transmit = 1'b0;
    for (int i = 0; i < 60 && done_cnt == s_done; i++) begin
      tick();
      out_ready = !out_ready;
    end
    out_ready = 1'b1;
    chk("bp_done", done_cnt - s_done, 32'd1);
    chk("bp_sb_empty", exp_q.size(), 32'd0);
    chk("bp_rd_cnt", rd_cnt - s_rd, 32'd3);
    tick();

    // Underrun: one byte of four, then FIFO stays empty
    s_done = done_cnt; s_eop = eop_cnt;
    push_fifo(8'h77);
    push_exp(8'h80, 1'b0); push_exp(8'hC3, 1'b0); push_exp(8'h77, 1'b0);
    tx_transmit = 1'b1; tx_len = 10'd4;
    tick();
    tx_transmit = 1'b0;
    tick(); tick();
    chk("ur_byte", {23'd0, out_valid, out_data}, 32'h177);
    chk("ur_rd", {31'd0, fifo_rd}, 32'd1);
    tick();
    chk("ur_empty_start", {30'd0, out_valid, sending}, 32'd1);
    s_abort = abort_cnt;
    repeat (15) tick();
    chk("ur_no_early_abort", {31'd0, tx_abort}, 32'd0);
    chk("ur_abort_cnt_early", abort_cnt - s_abort, 32'd0);
    tick();
    chk("ur_abort", {29'd0, tx_abort, sending, out_eop}, 32'd4);
    push_exp(8'h80, 1'b0); push_exp(8'h5A, 1'b1);
    tx_send_bad = 1'b1; tick(); tx_send_bad = 1'b0;
    chk("ur_new_req", {31'd0, sending}, 32'd1);
    wait_done(s_done, 20, "nak_done_timeout");
    chk("ur_only_nak_done", done_cnt - s_done, 32'd1);
    chk("ur_only_nak_eop", eop_cnt - s_eop, 32'd1);
    chk("ur_abort_cnt", abort_cnt - s_abort, 32'd1);
    chk("ur_sb_empty", exp_q.size(), 32'd0);

    // Zero-length data packet
    s_done = done_cnt; s_rd = rd_cnt;
    push_exp(8'h80, 1'b0); push_exp(8'hC3, !CRC_ON);
`ifdef TCU_CRC16_EN
    push_exp(8'h00, 1'b0); push_exp(8'h00, 1'b1);
`endif
    tx_transmit = 1'b1; tx_len = 10'd0;
    tick();
    tx_transmit = 1'b0;
    wait_done(s_done, 20, "len0_done_timeout");
    chk("len0_sb_empty", exp_q.size(), 32'd0);
    chk("len0_rd_cnt", rd_cnt - s_rd, 32'd0);

    // Reset in the middle of a 5-byte payload
    s_done = done_cnt; s_abort = abort_cnt; s_eop = eop_cnt;
    for (int i = 1; i <= 5; i++) push_fifo(8'(i));
    push_exp(8'h80, 1'b0); push_exp(8'hC3, 1'b0); push_exp(8'h01, 1'b0);
    tx_transmit = 1'b1; tx_len = 10'd5;
    tick();
    tx_transmit = 1'b0;
    tick(); tick(); tick();
    chk("mid_byte2", {23'd0, out_valid, out_data}, 32'h102);
    rst = 1'b1; out_ready = 1'b0;
    tick();
    chk("mid_rst_outs", {21'd0, out_data, out_valid, out_eop, sending}, 32'd0);
    chk("mid_rst_pulses", {29'd0, tx_done, tx_abort, fifo_rd}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    chk("mid_sb_empty", exp_q.size(), 32'd0);
    tick();
    push_exp(8'h80, 1'b0); push_exp(8'hD2, 1'b1);
    tx_send_good = 1'b1; tick(); tx_send_good = 1'b0;
    wait_done(s_done, 20, "post_rst_ack_timeout");
    chk("post_rst_sb_empty", exp_q.size(), 32'd0);
    chk("post_rst_eop_cnt", eop_cnt - s_eop, 32'd1);
    chk("post_rst_abort_cnt", abort_cnt - s_abort, 32'd0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
